ctl_perf_sampler: RTL
=====================

CTL_PERF_SAMPLER -- requirements
Module: ctl_perf_sampler

Interface
REQ-001 SHALL have parameter N_REGS, default 13: number of 32-bit counter registers swept per sample (1..16).
REQ-002 SHALL have parameter HDR_TAG, default 8'hA5: tag in header word bits [31:24].
REQ-003 SHALL use one clock and a synchronous, active-high reset: clk_ni input 1 (sole clock); rst_ni input 1 (synchronous, active-high).
REQ-004 i_enable  input  1  global sampling enable; gates the interval timer and sweep start.
REQ-005 i_period  input  16  sample interval in clk_ni cycles; 0 = periodic sampling off.
REQ-006 i_trigger  input  1  one-cycle software sample request.
REQ-007 i_clear_on_read  input  1  zero each counter after reading it.
REQ-008 o_block_sel, o_mni_reg_valid, o_mni_reg_write, o_mni_reg_ben, o_mni_reg_adr1, o_read_low  output  1 each  counter-block register access strobes.
REQ-009 o_reg_sel_enc  output  4  counter register index.
REQ-010 i_dt_out  input  16  counter read data, combinational from address.
REQ-011 o_data  output  32  sample stream word; o_valid  output  1; i_stall  input  1  consumer backpressure.
REQ-012 o_overrun  output  1  sticky: a sample start was dropped.

Function
REQ-013 Timer SHALL count clk_ni cycles while i_enable=1 and i_period!=0, and raise tick when count reaches i_period-1, then restart at 0; i_period change SHALL restart count at 0.
REQ-014 Sweep start = (tick | i_trigger) & i_enable; start in any state other than IDLE SHALL set o_overrun and be dropped.
REQ-015 States: IDLE, HDR, RD_LO, RD_HI, CLR_LO, CLR_HI, PUSH.
REQ-016 IDLE -> HDR on start; sel counter <= 0.
REQ-017 HDR SHALL drive o_valid=1, o_data={HDR_TAG, 4'b0, N_REGS-1 [3:0], seq[15:0]}; leave to RD_LO in the first cycle with i_stall=0; seq increments by 1 on that cycle, wraps 16'hFFFF -> 0.
REQ-018 RD_LO: one cycle, o_block_sel=o_mni_reg_valid=1, o_read_low=1, o_mni_reg_write=0; capture i_dt_out into data[15:0] same cycle.
REQ-019 RD_HI: one cycle, same strobes with o_read_low=0; capture i_dt_out into data[31:16].
REQ-020 After RD_HI: to CLR_LO if i_clear_on_read=1 (sampled in RD_HI), else PUSH.
REQ-021 CLR_LO/CLR_HI: one cycle each, o_block_sel=o_mni_reg_valid=o_mni_reg_write=o_mni_reg_ben=1, o_mni_reg_adr1=0/1; then PUSH.
REQ-022 PUSH SHALL hold o_valid=1, o_data=captured word stable until a cycle with i_stall=0; then sel+1 -> RD_LO, or IDLE if sel==N_REGS-1.
REQ-023 o_data/o_valid SHALL NOT change while o_valid=1 and i_stall=1.
REQ-024 Outside RD/CLR states all access strobes SHALL be 0; o_reg_sel_enc = sel at all times.
REQ-025 Events occurring between RD and CLR of the same register are lost; accepted, not corrected.
REQ-026 i_enable deassert mid-sweep SHALL NOT abort the sweep.
REQ-027 Sample latency: header on o_valid 1 cycle after start; with i_stall=0 one sweep = 1+N_REGS*(3 or 5) cycles.

Reset
REQ-028 On rst_ni=1 at clk_ni edge: state IDLE, sel 0, seq 0, timer 0, o_overrun 0, o_valid 0, o_data 0, all access strobes 0; reset mid-sweep SHALL abandon the sweep with no further reads/writes.
REQ-029 o_overrun SHALL clear only on reset.

Structure
REQ-030 State encoding, HDR_TAG default and header field positions SHALL live in shared package ctl_perf_pkg.
REQ-031 Interval timer SHALL be sub-module ctl_perf_timer (i_enable, i_period -> o_tick); all else in one module.

Verification
REQ-032 N_REGS=2, i_trigger pulse, counter model regs {0x0001_0002, 0x0003_0004}, i_stall=0 -> stream 0xA501_0000, 0x0001_0002, 0x0003_0004; idle after 8 cycles.
REQ-033 i_period=100, i_enable=1 for 1000 cycles -> exactly 10 headers, seq 0..9, header spacing 100 cycles.
REQ-034 i_clear_on_read=1, reg0=0x1234_5678 -> word 0x1234_5678 emitted, then both halves write-zero (adr1=0 then 1, ben=1); next sweep reads 0x0000_0000.
REQ-035 i_stall=1 for 20 cycles during PUSH of reg0 -> o_data held constant, no reads issued, resumes RD_LO reg1 one cycle after stall release.
REQ-036 i_trigger during active sweep -> o_overrun=1 and remains 1; sweep completes unaffected; rst_ni clears it.
REQ-037 rst_ni asserted in RD_HI -> next cycle strobes 0, o_valid 0, state IDLE; following trigger yields header seq 0.

Source files
------------

// File: rtl/ctl_perf_pkg.sv
// Shared definitions for the performance-counter sampler: sweep states,
// default header tag and header word layout.
package ctl_perf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_RD_LO,
    ST_RD_HI,
    ST_CLR_LO,
    ST_CLR_HI,
    ST_PUSH
  } state_t;

  localparam logic [7:0]  HDR_TAG_DEFAULT = 8'hA5;
  localparam int unsigned HDR_TAG_LSB     = 24;
  localparam int unsigned HDR_CNT_LSB     = 16;
  localparam int unsigned HDR_SEQ_LSB     = 0;

  // Header: {tag, 4'b0, register count minus one, sequence number}
  function automatic logic [31:0] hdr_word(input logic [7:0]  tag,
                                           input logic [3:0]  last,
                                           input logic [15:0] seq);
    logic [31:0] w;
    w = '0;
    w[HDR_TAG_LSB +: 8]  = tag;
    w[HDR_CNT_LSB +: 4]  = last;
    w[HDR_SEQ_LSB +: 16] = seq;
    return w;
  endfunction

endpackage

// File: rtl/ctl_perf_timer.sv
// Interval timer: one-cycle tick every i_period enabled cycles; a period
// change restarts the count.
module ctl_perf_timer (
  input  logic        clk_ni,
  input  logic        rst_ni,
  input  logic        i_enable,
  input  logic [15:0] i_period,
  output logic        o_tick
);

  logic [15:0] count_q;
  logic [15:0] period_q;
  logic [15:0] count_eff;
  logic        run;

  // A changed period is treated as count 0 in the same cycle it is seen
  always_comb begin
    run       = i_enable && (i_period != '0);
    count_eff = (i_period != period_q) ? '0 : count_q;
    o_tick    = run && (count_eff == (i_period - 16'd1));
  end

  always_ff @(posedge clk_ni) begin
    if (rst_ni) begin
      count_q  <= '0;
      period_q <= '0;
    end else begin
      period_q <= i_period;
      if (!run || o_tick) count_q <= '0;
      else                count_q <= count_eff + 16'd1;
    end
  end

endmodule

// File: rtl/ctl_perf_sampler.sv
// Sweeps N_REGS 32-bit counters through the 16-bit counter-block port and
// streams a header plus one word per counter, with optional clear-on-read.
module ctl_perf_sampler
  import ctl_perf_pkg::*;
#(
  parameter int unsigned N_REGS  = 13,
  parameter logic [7:0]  HDR_TAG = HDR_TAG_DEFAULT
) (
  input  logic        clk_ni,
  input  logic        rst_ni,
  input  logic        i_enable,
  input  logic [15:0] i_period,
  input  logic        i_trigger,
  input  logic        i_clear_on_read,
  output logic        o_block_sel,
  output logic        o_mni_reg_valid,
  output logic        o_mni_reg_write,
  output logic        o_mni_reg_ben,
  output logic        o_mni_reg_adr1,
  output logic        o_read_low,
  output logic [3:0]  o_reg_sel_enc,
  input  logic [15:0] i_dt_out,
  output logic [31:0] o_data,
  output logic        o_valid,
  input  logic        i_stall,
  output logic        o_overrun
);

  localparam logic [3:0] LAST = 4'(N_REGS - 1);

  state_t      state_q, state_d;
  logic [3:0]  sel_q, sel_d;
  logic [15:0] seq_q, seq_d;
  logic [31:0] data_q, data_d;
  logic        overrun_q;
  logic        tick;
  logic        start;

  ctl_perf_timer u_timer (
    .clk_ni   (clk_ni),
    .rst_ni   (rst_ni),
    .i_enable (i_enable),
    .i_period (i_period),
    .o_tick   (tick)
  );

  assign start         = (tick || i_trigger) && i_enable;
  assign o_reg_sel_enc = sel_q;
  assign o_overrun     = overrun_q;

  always_ff @(posedge clk_ni) begin
    if (rst_ni) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      seq_q     <= '0;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      seq_q     <= seq_d;
      data_q    <= data_d;
      overrun_q <= overrun_q || (start && (state_q != ST_IDLE));
    end
  end

  always_comb begin
    state_d         = state_q;
    sel_d           = sel_q;
    seq_d           = seq_q;
    data_d          = data_q;
    o_block_sel     = 1'b0;
    o_mni_reg_valid = 1'b0;
    o_mni_reg_write = 1'b0;
    o_mni_reg_ben   = 1'b0;
    o_mni_reg_adr1  = 1'b0;
    o_read_low      = 1'b0;
    o_valid         = 1'b0;
    o_data          = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_HDR;
          sel_d   = '0;
        end
      end
      ST_HDR: begin
        o_valid = 1'b1;
        o_data  = hdr_word(HDR_TAG, LAST, seq_q);
        if (!i_stall) begin
          state_d = ST_RD_LO;
          seq_d   = seq_q + 16'd1;
        end
      end
      ST_RD_LO: begin
        o_block_sel     = 1'b1;
        o_mni_reg_valid = 1'b1;
        o_read_low      = 1'b1;
        data_d          = {data_q[31:16], i_dt_out};
        state_d         = ST_RD_HI;
      end
      ST_RD_HI: begin
        o_block_sel     = 1'b1;
        o_mni_reg_valid = 1'b1;
        data_d          = {i_dt_out, data_q[15:0]};
        state_d         = i_clear_on_read ? ST_CLR_LO : ST_PUSH;
      end
      ST_CLR_LO: begin
        o_block_sel     = 1'b1;
        o_mni_reg_valid = 1'b1;
        o_mni_reg_write = 1'b1;
        o_mni_reg_ben   = 1'b1;
        state_d         = ST_CLR_HI;
      end
      ST_CLR_HI: begin
        o_block_sel     = 1'b1;
        o_mni_reg_valid = 1'b1;
        o_mni_reg_write = 1'b1;
        o_mni_reg_ben   = 1'b1;
        o_mni_reg_adr1  = 1'b1;
        state_d         = ST_PUSH;
      end
      ST_PUSH: begin
        o_valid = 1'b1;
        o_data  = data_q;
        if (!i_stall) begin
          if (sel_q == LAST) begin
            state_d = ST_IDLE;
          end else begin
            sel_d   = sel_q + 4'd1;
            state_d = ST_RD_LO;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
